// File: rtl/gshare_pkg.sv
// Shared definitions for the gshare training-update scheduler: default
// widths/depths and the queued update payload.
package gshare_pkg;

    localparam int GS_N       = 7;
    localparam int GS_DEPTH   = 4;
    localparam int GS_AGE_MAX = 3;

    // One resolved-branch training update as queued per requester.
    typedef struct packed {
        logic            taken;
        logic            mispred;
        logic [GS_N-1:0] pc;
        logic [GS_N-1:0] history;
    } train_req_t;

    // Identifies a requester port; also used as the round-robin "last granted".
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/gshare_train_fifo.sv
// Per-requester update FIFO. Push on full is ignored, pop on empty is ignored,
// and flush discards the whole contents in one edge (flush wins over push/pop).
module gshare_train_fifo
    import gshare_pkg::*;
#(
    parameter int  DEPTH = GS_DEPTH,
    parameter type T     = train_req_t
) (
    input  logic clk,
    input  logic areset,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Next-state for pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_ok  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
        else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    // Control state: cleared asynchronously, emptied synchronously by flush.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/gshare_train_sched.sv
// Arbitrates two pipes' resolved-branch updates onto a single predictor
// training port. Priority: starving (aged-out) queue, then mispredicts,
// then round-robin. The chosen head is registered onto train_*.
// The payload type is shared with the package, so N must equal GS_N.
module gshare_train_sched
    import gshare_pkg::*;
#(
    parameter int N       = GS_N,
    parameter int DEPTH   = GS_DEPTH,
    parameter int AGE_MAX = GS_AGE_MAX
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_taken,
    input  logic         req0_mispred,
    input  logic [N-1:0] req0_pc,
    input  logic [N-1:0] req0_history,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_taken,
    input  logic         req1_mispred,
    input  logic [N-1:0] req1_pc,
    input  logic [N-1:0] req1_history,
    input  logic         flush,
    output logic         train_valid,
    output logic         train_taken,
    output logic         train_mispredicted,
    output logic [N-1:0] train_pc,
    output logic [N-1:0] train_history,
    output logic [15:0]  mispred_count
);

    localparam int            AGW       = $clog2(AGE_MAX + 1);
    localparam logic [AGW-1:0] AGE_MAX_V = AGW'(AGE_MAX);

    train_req_t     in0, in1, head0, head1, gsel;
    logic           full0, full1, empty0, empty1;
    logic           boost0, boost1, both, sel1, gnt0, gnt1, gnt_any;
    logic [AGW-1:0] age0_q, age0_d, age1_q, age1_d;
    port_e          last_q, last_d;
    logic           valid_q, valid_d;
    train_req_t     data_q, data_d;
    logic [15:0]    cnt_q, cnt_d;

    assign in0 = '{taken: req0_taken, mispred: req0_mispred, pc: req0_pc, history: req0_history};
    assign in1 = '{taken: req1_taken, mispred: req1_mispred, pc: req1_pc, history: req1_history};

    gshare_train_fifo #(.DEPTH(DEPTH), .T(train_req_t)) u_fifo0 (
        .clk(clk), .areset(areset), .flush(flush),
        .push(req0_valid), .pop(gnt0), .din(in0),
        .head(head0), .full(full0), .empty(empty0)
    );

    gshare_train_fifo #(.DEPTH(DEPTH), .T(train_req_t)) u_fifo1 (
        .clk(clk), .areset(areset), .flush(flush),
        .push(req1_valid), .pop(gnt1), .din(in1),
        .head(head1), .full(full1), .empty(empty1)
    );

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    assign boost0 = !empty0 && (age0_q == AGE_MAX_V);
    assign boost1 = !empty1 && (age1_q == AGE_MAX_V);
    assign both   = !empty0 && !empty1;

    // Contest between two non-empty heads: age boost, then mispredict, then round-robin.
    always_comb begin
        sel1 = 1'b0;
        if (boost0 != boost1)
            sel1 = boost1;
        else if (!boost0 && (head0.mispred != head1.mispred))
            sel1 = head1.mispred;
        else
            sel1 = (last_q == PORT0);
    end

    // A lone non-empty queue wins outright; nothing issues on a flush edge.
    assign gnt0    = !flush && !empty0 && (!both || !sel1);
    assign gnt1    = !flush && !empty1 && (!both || sel1);
    assign gnt_any = gnt0 || gnt1;
    assign gsel    = gnt1 ? head1 : head0;

    // Next state for age counters, round-robin pointer, output registers and mispredict count.
    always_comb begin
        age0_d = age0_q;
        if (flush || empty0 || gnt0)  age0_d = '0;
        else if (age0_q != AGE_MAX_V) age0_d = age0_q + 1'b1;
        age1_d = age1_q;
        if (flush || empty1 || gnt1)  age1_d = '0;
        else if (age1_q != AGE_MAX_V) age1_d = age1_q + 1'b1;
        last_d  = gnt_any ? (gnt1 ? PORT1 : PORT0) : last_q;
        valid_d = gnt_any;
        data_d  = gnt_any ? gsel : data_q;
        cnt_d   = cnt_q;
        if (gnt_any && gsel.mispred && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Scheduler state; reset leaves port 0 as the winner of the first tie.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            age0_q  <= '0;
            age1_q  <= '0;
            last_q  <= PORT1;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            age0_q  <= age0_d;
            age1_q  <= age1_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign train_valid        = valid_q;
    assign train_taken        = data_q.taken;
    assign train_mispredicted = data_q.mispred;
    assign train_pc           = data_q.pc;
    assign train_history      = data_q.history;
    assign mispred_count      = cnt_q;

endmodule

// File: tb/tb_gshare_train_sched.sv
// Bench for gshare_train_sched: queue-level reference model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_gshare_train_sched;
    import gshare_pkg::*;

    localparam int DEPTH   = 4;
    localparam int AGE_MAX = 3;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       req0_valid = 0, req0_taken = 0, req0_mispred = 0;
    logic [6:0] req0_pc = 0, req0_history = 0;
    logic       req1_valid = 0, req1_taken = 0, req1_mispred = 0;
    logic [6:0] req1_pc = 0, req1_history = 0;
    logic       flush = 0;
    logic       req0_ready, req1_ready;
    logic       train_valid, train_taken, train_mispredicted;
    logic [6:0] train_pc, train_history;
    logic [15:0] mispred_count;

    gshare_train_sched #(.N(7), .DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .areset(areset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_taken(req0_taken),
        .req0_mispred(req0_mispred), .req0_pc(req0_pc), .req0_history(req0_history),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_taken(req1_taken),
        .req1_mispred(req1_mispred), .req1_pc(req1_pc), .req1_history(req1_history),
        .flush(flush),
        .train_valid(train_valid), .train_taken(train_taken),
        .train_mispredicted(train_mispredicted), .train_pc(train_pc),
        .train_history(train_history), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (queues + plain rules) ----------------
    train_req_t m_q0[$], m_q1[$];
    int         m_age0 = 0, m_age1 = 0;
    int         m_last = 1;
    int         m_cnt  = 0;
    bit         m_tv   = 0;
    train_req_t m_out  = '0;
    int         m_g;
    bit         m_a0, m_a1, m_b0, m_b1;
    train_req_t m_e0, m_e1, m_pop;

    always @(posedge clk) begin
        if (areset) begin
            m_q0.delete(); m_q1.delete();
            m_age0 = 0; m_age1 = 0; m_last = 1; m_cnt = 0; m_tv = 0; m_out = '0;
        end else begin
            m_a0 = req0_valid && (m_q0.size() < DEPTH);
            m_a1 = req1_valid && (m_q1.size() < DEPTH);
            m_e0 = '{taken: req0_taken, mispred: req0_mispred, pc: req0_pc, history: req0_history};
            m_e1 = '{taken: req1_taken, mispred: req1_mispred, pc: req1_pc, history: req1_history};
            if (flush) begin
                m_q0.delete(); m_q1.delete();
                m_age0 = 0; m_age1 = 0; m_tv = 0;
            end else begin
                m_g = -1;
                if (m_q0.size() > 0 && m_q1.size() > 0) begin
                    m_b0 = (m_age0 == AGE_MAX);
                    m_b1 = (m_age1 == AGE_MAX);
                    if (m_b0 && !m_b1)      m_g = 0;
                    else if (m_b1 && !m_b0) m_g = 1;
                    else if (!m_b0 && m_q0[0].mispred != m_q1[0].mispred)
                        m_g = m_q0[0].mispred ? 0 : 1;
                    else
                        m_g = (m_last == 0) ? 1 : 0;
                end else if (m_q0.size() > 0) m_g = 0;
                else if (m_q1.size() > 0)     m_g = 1;
                if (m_q0.size() == 0 || m_g == 0) m_age0 = 0;
                else if (m_age0 < AGE_MAX)        m_age0++;
                if (m_q1.size() == 0 || m_g == 1) m_age1 = 0;
                else if (m_age1 < AGE_MAX)        m_age1++;
                if (m_g >= 0) begin
                    m_pop = (m_g == 0) ? m_q0.pop_front() : m_q1.pop_front();
                    m_tv = 1; m_out = m_pop; m_last = m_g;
                    if (m_pop.mispred && m_cnt < 65535) m_cnt++;
                end else begin
                    m_tv = 0;
                end
                if (m_a0) m_q0.push_back(m_e0);
                if (m_a1) m_q1.push_back(m_e1);
            end
        end
    end

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("req0_ready", 32'(req0_ready), 32'(m_q0.size() < DEPTH));
            chk("req1_ready", 32'(req1_ready), 32'(m_q1.size() < DEPTH));
            chk("train_valid", 32'(train_valid), 32'(m_tv));
            chk("train_taken", 32'(train_taken), 32'(m_out.taken));
            chk("train_mispred", 32'(train_mispredicted), 32'(m_out.mispred));
            chk("train_pc", 32'(train_pc), 32'(m_out.pc));
            chk("train_history", 32'(train_history), 32'(m_out.history));
            chk("mispred_count", 32'(mispred_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic step(input logic v0, input logic [6:0] pc0, input logic m0,
                        input logic v1, input logic [6:0] pc1, input logic m1,
                        input logic fl);
        req0_valid = v0; req0_pc = pc0; req0_history = pc0 ^ 7'h55;
        req0_taken = pc0[0]; req0_mispred = m0;
        req1_valid = v1; req1_pc = pc1; req1_history = pc1 ^ 7'h2A;
        req1_taken = pc1[1]; req1_mispred = m1;
        flush = fl;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; flush = 0;
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1;

        // Reset state and single push latency.
        do_reset();
        chk("rst_ready0", 32'(req0_ready), 32'd1);
        chk("rst_ready1", 32'(req1_ready), 32'd1);
        chk("rst_valid", 32'(train_valid), 32'd0);
        chk("rst_pc", 32'(train_pc), 32'd0);
        chk("rst_count", 32'(mispred_count), 32'd0);
        req0_valid = 1; req0_pc = 7'h12; req0_history = 7'h05; req0_taken = 1; req0_mispred = 0;
        @(negedge clk);
        req0_valid = 0;
        chk("lat_valid_early", 32'(train_valid), 32'd0);
        chk("lat_ready0", 32'(req0_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lat_valid", 32'(train_valid), 32'd1);
        chk("lat_pc", 32'(train_pc), 32'h12);
        chk("lat_hist", 32'(train_history), 32'h05);
        chk("lat_taken", 32'(train_taken), 32'd1);

        // Simultaneous non-mispredict pushes: port 0 then port 1, ties alternate.
        do_reset();
        step(1, 7'h21, 0, 1, 7'h31, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tie_first", 32'(train_pc), 32'h21);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tie_second", 32'(train_pc), 32'h31);
        step(1, 7'h22, 0, 1, 7'h32, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tie_third", 32'(train_pc), 32'h22);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("tie_fourth", 32'(train_pc), 32'h32);

        // Mispredict head on port 1 beats a non-mispredict stream on port 0.
        do_reset();
        step(1, 7'h40, 0, 1, 7'h50, 1, 0);
        step(1, 7'h41, 0, 0, 0, 0, 0);
        chk("misp_pc", 32'(train_pc), 32'h50);
        chk("misp_count", 32'(mispred_count), 32'd1);
        step(1, 7'h42, 0, 0, 0, 0, 0);
        chk("misp_next", 32'(train_pc), 32'h40);

        // Anti-starvation: port 0 wins after exactly AGE_MAX losses.
        do_reset();
        step(1, 7'h60, 0, 1, 7'h70, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 7'(7'h71 + i), 1, 0);
            if (i == 2) chk("age_loss3", 32'(train_pc), 32'h72);
        end
        chk("age_boost_pc", 32'(train_pc), 32'h60);
        chk("age_boost_count", 32'(mispred_count), 32'd3);

        // Fill port 0 to full, then pop with a rejected push, then push+pop together.
        do_reset();
        step(1, 7'h10, 0, 1, 7'h50, 1, 0);
        step(1, 7'h11, 0, 1, 7'h51, 1, 0);
        step(1, 7'h12, 0, 1, 7'h52, 1, 0);
        step(1, 7'h13, 0, 0, 0, 0, 0);
        chk("full_ready0", 32'(req0_ready), 32'd0);
        chk("full_pc", 32'(train_pc), 32'h52);
        step(1, 7'h14, 0, 0, 0, 0, 0);
        chk("pop_ready0", 32'(req0_ready), 32'd1);
        chk("pop_pc", 32'(train_pc), 32'h10);
        step(1, 7'h15, 0, 0, 0, 0, 0);
        chk("pushpop_ready0", 32'(req0_ready), 32'd1);
        chk("pushpop_pc", 32'(train_pc), 32'h11);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);

        // Flush with concurrent pushes while both queues hold entries.
        do_reset();
        step(1, 7'h01, 1, 1, 7'h02, 0, 0);
        step(1, 7'h03, 0, 1, 7'h04, 0, 0);
        chk("pre_flush_count", 32'(mispred_count), 32'd1);
        step(1, 7'h05, 0, 1, 7'h06, 0, 1);
        chk("flush_valid", 32'(train_valid), 32'd0);
        chk("flush_ready0", 32'(req0_ready), 32'd1);
        chk("flush_count", 32'(mispred_count), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flush_empty", 32'(train_valid), 32'd0);

        // Randomized traffic, including occasional flush and mid-operation reset.
        for (int c = 0; c < 3000; c++) begin
            req0_valid   = ($urandom_range(0, 9) < 6);
            req0_pc      = 7'($urandom);
            req0_history = 7'($urandom);
            req0_taken   = 1'($urandom);
            req0_mispred = ($urandom_range(0, 9) < 3);
            req1_valid   = ($urandom_range(0, 9) < 6);
            req1_pc      = 7'($urandom);
            req1_history = 7'($urandom);
            req1_taken   = 1'($urandom);
            req1_mispred = ($urandom_range(0, 9) < 4);
            flush        = ($urandom_range(0, 49) == 0);
            areset       = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0; flush = 0; areset = 0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
